// File: rtl/sm83_fetch_if.sv
// Fetch-stage bundle: memory read port, control-flow redirect and the
// instruction handshake toward decode. The fetch unit is the master.
interface sm83_fetch_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic        instr_is_cb;
  logic [15:0] instr_imm;
  logic [15:0] instr_pc;
  logic [15:0] instr_next_pc;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata, mem_ack,
    input  redir_valid, redir_pc,
    output instr_valid, instr_opcode, instr_is_cb, instr_imm, instr_pc, instr_next_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata, mem_ack,
    output redir_valid, redir_pc,
    input  instr_valid, instr_opcode, instr_is_cb, instr_imm, instr_pc, instr_next_pc,
    output instr_ready
  );
endinterface

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch: reads opcode/prefix/immediate bytes at the PC and
// presents one whole instruction to decode; redirects reload the PC.
module sm83_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  sm83_fetch_if.master bus
);
  localparam logic [2:0] FETCH_OP = 3'd0;
  localparam logic [2:0] FETCH_CB = 3'd1;
  localparam logic [2:0] FETCH_LO = 3'd2;
  localparam logic [2:0] FETCH_HI = 3'd3;
  localparam logic [2:0] PRESENT  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_target;
  logic        r_drain;
  logic        r_hi_pend;
  logic        r_valid;
  logic        r_is_cb;
  logic [7:0]  r_opcode;
  logic [15:0] r_imm;
  logic [15:0] r_ipc;
  logic [15:0] r_next_pc;

  logic        w_fetching;
  logic        w_ack;
  logic [15:0] w_pc_inc;

  // Number of immediate bytes following an unprefixed opcode.
  function automatic logic [1:0] imm_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8, 8'hEE,
      8'hF0, 8'hF6, 8'hF8, 8'hFE:
        imm_len = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        imm_len = 2'd2;
      default:
        imm_len = 2'd0;
    endcase
  endfunction

  assign w_fetching = (r_state != PRESENT);
  assign w_ack      = w_fetching & bus.mem_ack;
  assign w_pc_inc   = r_pc + 16'd1;

  assign bus.mem_rd        = w_fetching & ~i_rst;
  assign bus.mem_addr      = r_pc;
  assign bus.instr_valid   = r_valid;
  assign bus.instr_opcode  = r_opcode;
  assign bus.instr_is_cb   = r_is_cb;
  assign bus.instr_imm     = r_imm;
  assign bus.instr_pc      = r_ipc;
  assign bus.instr_next_pc = r_next_pc;

  // Fetch sequencer, redirect/drain handling and instruction output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= FETCH_OP;
      r_pc      <= RESET_PC;
      r_target  <= 16'h0000;
      r_drain   <= 1'b0;
      r_hi_pend <= 1'b0;
      r_valid   <= 1'b0;
      r_is_cb   <= 1'b0;
      r_opcode  <= 8'h00;
      r_imm     <= 16'h0000;
      r_ipc     <= 16'h0000;
      r_next_pc <= 16'h0000;
    end else if (r_drain) begin
      // The abandoned read must still complete before the PC may move.
      if (w_ack) begin
        r_pc    <= bus.redir_valid ? bus.redir_pc : r_target;
        r_drain <= 1'b0;
        r_state <= FETCH_OP;
      end else if (bus.redir_valid) begin
        r_target <= bus.redir_pc;
      end
    end else if (bus.redir_valid) begin
      if (w_fetching && !bus.mem_ack) begin
        r_drain  <= 1'b1;
        r_target <= bus.redir_pc;
      end else begin
        r_pc    <= bus.redir_pc;
        r_state <= FETCH_OP;
      end
      r_valid   <= 1'b0;
      r_is_cb   <= 1'b0;
      r_imm     <= 16'h0000;
      r_hi_pend <= 1'b0;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (w_ack) begin
            r_pc     <= w_pc_inc;
            r_ipc    <= r_pc;
            r_opcode <= bus.mem_rdata;
            r_imm    <= 16'h0000;
            r_is_cb  <= 1'b0;
            if (bus.mem_rdata == 8'hCB) begin
              r_state <= FETCH_CB;
            end else begin
              case (imm_len(bus.mem_rdata))
                2'd1: begin
                  r_hi_pend <= 1'b0;
                  r_state   <= FETCH_LO;
                end
                2'd2: begin
                  r_hi_pend <= 1'b1;
                  r_state   <= FETCH_LO;
                end
                default: begin
                  r_state   <= PRESENT;
                  r_valid   <= 1'b1;
                  r_next_pc <= w_pc_inc;
                end
              endcase
            end
          end
        end
        FETCH_CB: begin
          if (w_ack) begin
            r_pc      <= w_pc_inc;
            r_opcode  <= bus.mem_rdata;
            r_is_cb   <= 1'b1;
            r_state   <= PRESENT;
            r_valid   <= 1'b1;
            r_next_pc <= w_pc_inc;
          end
        end
        FETCH_LO: begin
          if (w_ack) begin
            r_pc       <= w_pc_inc;
            r_imm[7:0] <= bus.mem_rdata;
            if (r_hi_pend) begin
              r_state <= FETCH_HI;
            end else begin
              r_state   <= PRESENT;
              r_valid   <= 1'b1;
              r_next_pc <= w_pc_inc;
            end
          end
        end
        FETCH_HI: begin
          if (w_ack) begin
            r_pc        <= w_pc_inc;
            r_imm[15:8] <= bus.mem_rdata;
            r_hi_pend   <= 1'b0;
            r_state     <= PRESENT;
            r_valid     <= 1'b1;
            r_next_pc   <= w_pc_inc;
          end
        end
        PRESENT: begin
          if (bus.instr_ready) begin
            r_state <= FETCH_OP;
            r_valid <= 1'b0;
            r_is_cb <= 1'b0;
            r_imm   <= 16'h0000;
          end
        end
        default: begin
          r_state <= FETCH_OP;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sm83_fetch.sv
// Directed timing checks plus randomized fetch traffic compared against an
// instruction-length reference model walking a byte-array memory image.
module tb_sm83_fetch;
  logic clk = 1'b0;
  logic rst;
  logic rst_b;

  always #5 clk = ~clk;

  sm83_fetch_if bus_a ();
  sm83_fetch_if bus_b ();

  sm83_fetch #(.RESET_PC(16'h0000)) u_dut_a (.i_clk(clk), .i_rst(rst),   .bus(bus_a));
  sm83_fetch #(.RESET_PC(16'hFFFF)) u_dut_b (.i_clk(clk), .i_rst(rst_b), .bus(bus_b));

  // Second instance sees a zero-wait memory holding 3E at FFFF and 12 at 0000.
  assign bus_b.mem_ack   = bus_b.mem_rd;
  assign bus_b.mem_rdata = (bus_b.mem_addr == 16'hFFFF) ? 8'h3E :
                           ((bus_b.mem_addr == 16'h0000) ? 8'h12 : 8'h00);

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          errors = 0;
  int          waits  = 0;
  int          cnt    = 0;
  bit          rand_waits = 1'b0;
  logic [15:0] mpc;
  int          hs_count = 0;
  logic [7:0]  e_op;
  logic        e_cb;
  logic [15:0] e_imm;
  logic [15:0] e_nxt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int imm_bytes(input logic [7:0] op);
    if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                   8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                   8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6,
                   8'hF8, 8'hFE})
      return 1;
    if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4,
                   8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA,
                   8'hFA})
      return 2;
    return 0;
  endfunction

  // Decode the instruction that starts at pc in the memory image.
  task automatic model_instr(input logic [15:0] pc, output logic [7:0] op,
                             output logic cb, output logic [15:0] imm,
                             output logic [15:0] nxt);
    logic [15:0] p1;
    logic [15:0] p2;
    int n;
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    if (mem[pc] == 8'hCB) begin
      op = mem[p1]; cb = 1'b1; imm = 16'h0000; nxt = p2;
    end else begin
      op = mem[pc]; cb = 1'b0;
      n = imm_bytes(mem[pc]);
      if (n == 0) imm = 16'h0000;
      else if (n == 1) imm = {8'h00, mem[p1]};
      else imm = {mem[p2], mem[p1]};
      nxt = pc + 16'(1 + n);
    end
  endtask

  // Memory responder for instance A; called once per cycle before the edge.
  task automatic drive_bus();
    if (bus_a.mem_rd !== 1'b1) begin
      bus_a.mem_ack = 1'b0;
      cnt = rand_waits ? int'($urandom_range(0, 2)) : waits;
    end else if (cnt == 0) begin
      bus_a.mem_ack   = 1'b1;
      bus_a.mem_rdata = mem[bus_a.mem_addr];
      cnt = rand_waits ? int'($urandom_range(0, 2)) : waits;
    end else begin
      bus_a.mem_ack   = 1'b0;
      bus_a.mem_rdata = 8'($urandom);
      cnt--;
    end
  endtask

  task automatic tick();
    #1;
    drive_bus();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h00;
    mem[16'h0002] = 8'h31; mem[16'h0003] = 8'hFE; mem[16'h0004] = 8'hFF;
    mem[16'h0005] = 8'hCB; mem[16'h0006] = 8'h37;
    mem[16'h0007] = 8'hE0; mem[16'h0008] = 8'h44;
    mem[16'h0009] = 8'h3C;
    mem[16'h0200] = 8'h06; mem[16'h0201] = 8'h55;
    mem[16'h0150] = 8'h00;

    rst = 1'b1; rst_b = 1'b1;
    bus_a.redir_valid = 1'b0; bus_a.redir_pc = 16'h0000; bus_a.instr_ready = 1'b1;
    bus_a.mem_ack = 1'b0; bus_a.mem_rdata = 8'h00;
    bus_b.redir_valid = 1'b0; bus_b.redir_pc = 16'h0000; bus_b.instr_ready = 1'b0;

    @(negedge clk);
    tick();
    tick();
    chk("rst_mem_rd", bus_a.mem_rd, 1'b0);
    chk("rst_valid", bus_a.instr_valid, 1'b0);
    chk("rst_opcode", bus_a.instr_opcode, 8'h00);
    chk("rst_is_cb", bus_a.instr_is_cb, 1'b0);
    chk("rst_imm", bus_a.instr_imm, 16'h0000);
    chk("rst_pc", bus_a.instr_pc, 16'h0000);
    chk("rst_next_pc", bus_a.instr_next_pc, 16'h0000);
    chk("rst_b_mem_rd", bus_b.mem_rd, 1'b0);

    rst = 1'b0;
    #1;
    chk("c0_mem_rd", bus_a.mem_rd, 1'b1);
    chk("c0_addr", bus_a.mem_addr, 16'h0000);
    tick();
    chk("c1_valid", bus_a.instr_valid, 1'b1);
    chk("c1_pc", bus_a.instr_pc, 16'h0000);
    chk("c1_next_pc", bus_a.instr_next_pc, 16'h0001);
    chk("c1_opcode", bus_a.instr_opcode, 8'h00);
    chk("c1_mem_rd", bus_a.mem_rd, 1'b0);
    tick();
    chk("c2_valid", bus_a.instr_valid, 1'b0);
    chk("c2_addr", bus_a.mem_addr, 16'h0001);
    tick();
    chk("c3_valid", bus_a.instr_valid, 1'b1);
    chk("c3_pc", bus_a.instr_pc, 16'h0001);
    chk("c3_next_pc", bus_a.instr_next_pc, 16'h0002);

    tick();
    chk("ld16_b0_valid", bus_a.instr_valid, 1'b0);
    chk("ld16_b0_addr", bus_a.mem_addr, 16'h0002);
    tick();
    chk("ld16_b1_valid", bus_a.instr_valid, 1'b0);
    chk("ld16_b1_addr", bus_a.mem_addr, 16'h0003);
    tick();
    chk("ld16_b2_valid", bus_a.instr_valid, 1'b0);
    chk("ld16_b2_addr", bus_a.mem_addr, 16'h0004);
    tick();
    chk("ld16_valid", bus_a.instr_valid, 1'b1);
    chk("ld16_opcode", bus_a.instr_opcode, 8'h31);
    chk("ld16_imm", bus_a.instr_imm, 16'hFFFE);
    chk("ld16_is_cb", bus_a.instr_is_cb, 1'b0);
    chk("ld16_pc", bus_a.instr_pc, 16'h0002);
    chk("ld16_next_pc", bus_a.instr_next_pc, 16'h0005);

    tick(); tick(); tick();
    chk("cb_valid", bus_a.instr_valid, 1'b1);
    chk("cb_is_cb", bus_a.instr_is_cb, 1'b1);
    chk("cb_opcode", bus_a.instr_opcode, 8'h37);
    chk("cb_imm", bus_a.instr_imm, 16'h0000);
    chk("cb_pc", bus_a.instr_pc, 16'h0005);
    chk("cb_next_pc", bus_a.instr_next_pc, 16'h0007);

    tick(); tick(); tick();
    chk("ldh_valid", bus_a.instr_valid, 1'b1);
    chk("ldh_opcode", bus_a.instr_opcode, 8'hE0);
    chk("ldh_imm", bus_a.instr_imm, 16'h0044);
    chk("ldh_is_cb", bus_a.instr_is_cb, 1'b0);
    chk("ldh_next_pc", bus_a.instr_next_pc, 16'h0009);

    tick();
    bus_a.instr_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus_a.instr_valid, 1'b1);
      chk("stall_opcode", bus_a.instr_opcode, 8'h3C);
      chk("stall_pc", bus_a.instr_pc, 16'h0009);
      chk("stall_next_pc", bus_a.instr_next_pc, 16'h000A);
      chk("stall_mem_rd", bus_a.mem_rd, 1'b0);
      tick();
    end
    bus_a.instr_ready = 1'b1;
    bus_a.redir_valid = 1'b1;
    bus_a.redir_pc    = 16'h0200;
    tick();
    bus_a.redir_valid = 1'b0;
    chk("redir_hs_mem_rd", bus_a.mem_rd, 1'b1);
    chk("redir_hs_addr", bus_a.mem_addr, 16'h0200);
    chk("redir_hs_valid", bus_a.instr_valid, 1'b0);

    waits = 2;
    cnt   = 2;
    tick();
    chk("wait_op_addr", bus_a.mem_addr, 16'h0200);
    tick();
    tick();
    chk("wait_lo_addr", bus_a.mem_addr, 16'h0201);
    bus_a.redir_valid = 1'b1;
    bus_a.redir_pc    = 16'h0150;
    tick();
    bus_a.redir_valid = 1'b0;
    chk("drain1_mem_rd", bus_a.mem_rd, 1'b1);
    chk("drain1_addr", bus_a.mem_addr, 16'h0201);
    chk("drain1_valid", bus_a.instr_valid, 1'b0);
    tick();
    chk("drain2_mem_rd", bus_a.mem_rd, 1'b1);
    chk("drain2_addr", bus_a.mem_addr, 16'h0201);
    chk("drain2_valid", bus_a.instr_valid, 1'b0);
    tick();
    chk("drain_done_addr", bus_a.mem_addr, 16'h0150);
    chk("drain_done_mem_rd", bus_a.mem_rd, 1'b1);
    chk("drain_done_valid", bus_a.instr_valid, 1'b0);
    tick(); tick(); tick();
    chk("target_valid", bus_a.instr_valid, 1'b1);
    chk("target_pc", bus_a.instr_pc, 16'h0150);
    chk("target_next_pc", bus_a.instr_next_pc, 16'h0151);
    chk("target_opcode", bus_a.instr_opcode, 8'h00);

    rst_b = 1'b0;
    #1;
    chk("wrap_addr0", bus_b.mem_addr, 16'hFFFF);
    chk("wrap_mem_rd", bus_b.mem_rd, 1'b1);
    tick();
    chk("wrap_addr1", bus_b.mem_addr, 16'h0000);
    tick();
    chk("wrap_valid", bus_b.instr_valid, 1'b1);
    chk("wrap_opcode", bus_b.instr_opcode, 8'h3E);
    chk("wrap_imm", bus_b.instr_imm, 16'h0012);
    chk("wrap_pc", bus_b.instr_pc, 16'hFFFF);
    chk("wrap_next_pc", bus_b.instr_next_pc, 16'h0001);

    rand_waits = 1'b1;
    bus_a.instr_ready = 1'b0;
    bus_a.redir_valid = 1'b1;
    bus_a.redir_pc    = 16'($urandom);
    mpc = bus_a.redir_pc;
    tick();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus_a.instr_ready = ($urandom_range(0, 3) != 0);
      bus_a.redir_valid = ($urandom_range(0, 24) == 0);
      bus_a.redir_pc    = 16'($urandom);
      if (bus_a.instr_valid === 1'b1 && bus_a.instr_ready) begin
        model_instr(mpc, e_op, e_cb, e_imm, e_nxt);
        chk("rnd_pc", bus_a.instr_pc, mpc);
        chk("rnd_opcode", bus_a.instr_opcode, e_op);
        chk("rnd_is_cb", bus_a.instr_is_cb, e_cb);
        chk("rnd_imm", bus_a.instr_imm, e_imm);
        chk("rnd_next_pc", bus_a.instr_next_pc, e_nxt);
        mpc = e_nxt;
        hs_count++;
      end
      if (bus_a.redir_valid) mpc = bus_a.redir_pc;
      tick();
    end
    bus_a.redir_valid = 1'b0;
    chk("rnd_progress", (hs_count > 200), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm83_fetch.md
# sm83_fetch

Instruction fetch stage of the SM83 core. Reads opcode bytes from the memory bus at the internal PC, resolves the 0xCB prefix, gathers 8/16-bit immediates by opcode length, and presents one complete instruction (`instr_t`-compatible opcode byte plus immediate) to the decode/control stage over a valid/ready handshake. Control-flow redirects (JP/JR/CALL/RET/RST/interrupt vector) reload the PC from downstream.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_rd`  out  1  read request; held with `mem_addr` stable until `mem_ack`.
- `mem_addr`  out  16  read address (= current PC).
- `mem_rdata`  in  8  read data, valid when `mem_ack`.
- `mem_ack`  in  1  read completes this cycle (may be the same cycle as `mem_rd`).
- `redir_valid`  in  1  load new PC; flush current instruction.
- `redir_pc`  in  16  redirect target.
- `instr_valid`  out  1  complete instruction presented.
- `instr_ready`  in  1  decoder accepts when high with `instr_valid`.
- `instr_opcode`  out  8  opcode byte (second byte if CB-prefixed).
- `instr_is_cb`  out  1  opcode came after a 0xCB prefix.
- `instr_imm`  out  16  immediate; imm8 in [7:0] with [15:8]=0; imm16 little-endian (first byte = [7:0]).
- `instr_pc`  out  16  address of first byte (prefix or opcode).
- `instr_next_pc`  out  16  address following last byte (return address for CALL/RST).

## Operation
- States: `FETCH_OP`, `FETCH_CB`, `FETCH_LO`, `FETCH_HI`, `PRESENT`.
- `mem_rd` = 1 in every FETCH_* state, 0 in `PRESENT`; `mem_addr` = `pc_q`.
- On `mem_ack` in any FETCH_* state: capture byte, `pc_q <= pc_q + 1` (16-bit wrap, 0xFFFF→0x0000).
- `FETCH_OP`: record `instr_pc <= pc_q`. Byte 0xCB → `FETCH_CB`. Imm8 opcodes (06,0E,16,1E,26,2E,36,3E,10,18,20,28,30,38,C6,CE,D6,DE,E0,E6,E8,EE,F0,F6,F8,FE) → `FETCH_LO`. Imm16 opcodes (01,11,21,31,08,C2,C3,C4,CA,CC,CD,D2,D4,DA,DC,EA,FA) → `FETCH_LO` with hi-pending flag. All others (including illegal D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD) → `PRESENT`, imm = 0.
- `FETCH_CB`: byte → `instr_opcode`, `instr_is_cb=1` → `PRESENT`. CB opcodes never have immediates.
- `FETCH_LO`: byte → imm[7:0]; → `FETCH_HI` if hi-pending else `PRESENT`.
- `FETCH_HI`: byte → imm[15:8] → `PRESENT`.
- `PRESENT`: `instr_valid=1`, `instr_next_pc = pc_q`; outputs stable while `instr_ready=0`. Handshake → `FETCH_OP`, clear is_cb/imm.
- Redirect (`redir_valid`), any state:
  - No read outstanding (`PRESENT`, or FETCH_* with `mem_ack` this cycle, or FETCH_* not yet asserted): `pc_q <= redir_pc`, discard partial/presented instruction, → `FETCH_OP` next cycle.
  - FETCH_* without `mem_ack`: bus request must not be withdrawn; latch target, enter drain, keep `mem_rd`/`mem_addr` until `mem_ack`, discard data, then `pc_q <= target`, → `FETCH_OP`.
  - Redirect and handshake in the same cycle: instruction counts as consumed; redirect wins for next PC.
  - Redirect during drain: latest target overwrites latched target.
- HALT/STOP are not handled here; decoder stalls via `instr_ready=0`.

## Timing
- Reset: state `FETCH_OP`, `pc_q=RESET_PC`, `mem_rd=1` in the cycle after reset deasserts (0 while `rst` high), `mem_addr=RESET_PC`, `instr_valid=0`, `instr_opcode=0`, `instr_is_cb=0`, `instr_imm=0`, `instr_pc=0`, `instr_next_pc=0`, drain flag clear. Reset mid-fetch abandons the bus request immediately.
- Zero-wait memory (ack same cycle): n-byte instruction → `instr_valid` rises n cycles after first `mem_rd`; with `instr_ready` held high, throughput is one instruction per n+1 cycles.
- Each wait cycle (`mem_rd` without `mem_ack`) adds exactly one cycle.
- All outputs registered except `mem_rd`/`mem_addr` (decoded from registered state and `pc_q`).

## Test plan
- Reset, memory 00 00 at 0x0000, zero wait, ready=1 → NOP presented at cycle 1 (`instr_pc`=0000, `instr_next_pc`=0001) and cycle 3 (`instr_pc`=0001).
- Bytes 31 FE FF (LD SP,d16) → one instruction, opcode 31, imm 0xFFFE, `instr_next_pc`=0003, valid 3 cycles after first read.
- Bytes CB 37 → `instr_is_cb=1`, opcode 37, imm 0, `instr_next_pc`=0002; then E0 44 → opcode E0, imm 0x0044.
- `RESET_PC`=FFFF, byte 3E at FFFF and 12 at 0000 → `mem_addr` wraps to 0000, imm 0x0012, `instr_next_pc`=0001.
- 2 wait cycles per read, redirect to 0x0150 asserted during outstanding read of FETCH_LO → `mem_rd` held until ack, data discarded, next `mem_addr`=0150, no `instr_valid` for flushed instruction.
- `instr_ready`=0 for 5 cycles in `PRESENT` → outputs stable, no `mem_rd`; then ready and `redir_valid` same cycle → next fetch from `redir_pc`.
